hls_ctrl_perf_monitor: RTL and testbench

Synthesizable, parametrised monitor for N_CH HLS ap_ctrl_hs/ap_ctrl_chain handshake channels. Per channel it counts started and completed invocations, busy and back-pressure cycles, and measures per-invocation latency through a timestamp FIFO. It therefore supports overlapping (pipelined) invocations. It sits beside the accelerator top, taps each sub-module's ap_start/ap_ready/ap_done/ap_continue, and exposes results through a registered read port for on-chip debug or a CSR bridge.

---
 rtl/hls_mon_pkg.sv | 21 ++
 rtl/hls_ch_monitor.sv | 96 +++++++++
 rtl/hls_ctrl_perf_monitor.sv | 63 ++++++
 tb/tb_hls_ctrl_perf_monitor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hls_mon_pkg.sv
// hls_mon_pkg: shared read-select codes, status bit positions and saturating increment.
package hls_mon_pkg;
  typedef enum logic [2:0] {
    SEL_NSTART,
    SEL_NDONE,
    SEL_BUSY,
    SEL_STALL,
    SEL_LAT_LAST,
    SEL_LAT_MAX,
    SEL_STATUS,
    SEL_TS
  } rd_sel_e;
  localparam int ST_OVF = 0;
  localparam int ST_UNF = 1;
  localparam int ST_OCC_LSB = 2;
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] top;
    top = (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
    return (v == top) ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/hls_ch_monitor.sv
// hls_ch_monitor: one channel's handshake tracking, timestamp FIFO, counters and latency.
module hls_ch_monitor import hls_mon_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32,
  parameter int TS_W = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ap_start,
  input  logic                  ap_ready,
  input  logic                  ap_done,
  input  logic                  ap_continue,
  input  logic [TS_W-1:0]       ts_now,
  input  logic                  freeze,
  input  logic                  clear,
  output logic [7:0][CNT_W-1:0] fields
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  logic [TS_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wp, rp;
  logic [OCC_W-1:0] occ;
  logic pend, ovf, unf;
  logic [CNT_W-1:0] n_start, n_done, busy_cyc, stall_cyc, status;
  logic [TS_W-1:0] lat_last, lat_max, lat;
  logic start_ev, done_ev, empty, full, bypass, pop, push;
  always_comb begin
    start_ev = ap_start & ~pend;
    done_ev = ap_done & ap_continue;
    empty = occ == '0;
    full = occ == OCC_W'(DEPTH);
    bypass = start_ev & done_ev & empty;
    pop = done_ev & ~empty;
    push = start_ev & ~bypass & (~full | pop);
    lat = bypass ? '0 : ts_now - mem[rp];
    status = '0;
    status[ST_OVF] = ovf;
    status[ST_UNF] = unf;
    status[ST_OCC_LSB +: OCC_W] = occ;
    fields = '0;
    fields[SEL_NSTART] = n_start;
    fields[SEL_NDONE] = n_done;
    fields[SEL_BUSY] = busy_cyc;
    fields[SEL_STALL] = stall_cyc;
    fields[SEL_LAT_LAST] = CNT_W'(lat_last);
    fields[SEL_LAT_MAX] = CNT_W'(lat_max);
    fields[SEL_STATUS] = status;
    fields[SEL_TS] = CNT_W'(ts_now);
  end
  // FIFO motion continues through clear so in-flight latencies survive it
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pend <= 1'b0;
      wp <= '0;
      rp <= '0;
      occ <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      n_start <= '0;
      n_done <= '0;
      busy_cyc <= '0;
      stall_cyc <= '0;
      lat_last <= '0;
      lat_max <= '0;
    end else begin
      if (!freeze) begin
        pend <= (pend | ap_start) & ~ap_ready;
        wp <= wp + PTR_W'(push);
        rp <= rp + PTR_W'(pop);
        occ <= occ + OCC_W'(push) - OCC_W'(pop);
      end
      if (clear) begin
        ovf <= 1'b0;
        unf <= 1'b0;
        n_start <= '0;
        n_done <= '0;
        busy_cyc <= '0;
        stall_cyc <= '0;
        lat_last <= '0;
        lat_max <= '0;
      end else if (!freeze) begin
        if (start_ev) n_start <= CNT_W'(sat_inc(64'(n_start), CNT_W));
        if (done_ev) n_done <= CNT_W'(sat_inc(64'(n_done), CNT_W));
        if (!empty) busy_cyc <= CNT_W'(sat_inc(64'(busy_cyc), CNT_W));
        if (ap_done & ~ap_continue) stall_cyc <= CNT_W'(sat_inc(64'(stall_cyc), CNT_W));
        if (bypass | pop) begin
          lat_last <= lat;
          if (lat > lat_max) lat_max <= lat;
        end
        if (start_ev & ~bypass & full & ~pop) ovf <= 1'b1;
        if (done_ev & empty & ~start_ev) unf <= 1'b1;
      end
    end
  always_ff @(posedge clock)
    if (!freeze & push) mem[wp] <= ts_now;
endmodule

// File: rtl/hls_ctrl_perf_monitor.sv
// hls_ctrl_perf_monitor: per-channel HLS handshake perf counters with a registered read port.
module hls_ctrl_perf_monitor import hls_mon_pkg::*; #(
  parameter int N_CH = 3,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32,
  parameter int TS_W = 24
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [N_CH-1:0]                         ap_start,
  input  logic [N_CH-1:0]                         ap_ready,
  input  logic [N_CH-1:0]                         ap_done,
  input  logic [N_CH-1:0]                         ap_continue,
  input  logic                                    finish,
  input  logic                                    clear,
  input  logic                                    rd_en,
  input  logic [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0] rd_ch,
  input  logic [2:0]                              rd_sel,
  output logic [CNT_W-1:0]                        rd_data,
  output logic                                    rd_valid
);
  localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1;
  logic [TS_W-1:0] ts_now;
  logic freeze;
  logic [7:0][CNT_W-1:0] fields [N_CH];
  logic [CNT_W-1:0] rd_mux;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      ts_now <= '0;
      freeze <= 1'b0;
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (!freeze) ts_now <= ts_now + 1'b1;
      freeze <= clear ? 1'b0 : freeze | finish;
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    hls_ch_monitor #(
      .DEPTH(DEPTH),
      .CNT_W(CNT_W),
      .TS_W(TS_W)
    ) u_ch (
      .clock(clock),
      .reset(reset),
      .ap_start(ap_start[i]),
      .ap_ready(ap_ready[i]),
      .ap_done(ap_done[i]),
      .ap_continue(ap_continue[i]),
      .ts_now(ts_now),
      .freeze(freeze),
      .clear(clear),
      .fields(fields[i])
    );
  end
  // unmatched channel numbers fall through to zero
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < N_CH; c++)
      if (rd_ch == CH_W'(c)) rd_mux = fields[c][rd_sel];
  end
endmodule

// File: tb/tb_hls_ctrl_perf_monitor.sv
// tb_hls_ctrl_perf_monitor: directed and random stimulus against a queue-based channel model.
module tb_hls_ctrl_perf_monitor;
  localparam int N = 3, D = 4, CW = 8, TW = 5;
  localparam int CMAX = (1 << CW) - 1, TMASK = (1 << TW) - 1;
  typedef struct {int ch; int sel; int v;} exp_t;
  logic clock = 1'b0, reset = 1'b1;
  logic [N-1:0] ap_start = '0, ap_ready = '0, ap_done = '0, ap_continue = '1;
  logic finish = 1'b0, clear = 1'b0, rd_en = 1'b0;
  logic [1:0] rd_ch = '0;
  logic [2:0] rd_sel = '0;
  logic [CW-1:0] rd_data;
  logic rd_valid;
  int n_cmp = 0, n_fail = 0;
  exp_t exp_q[$];
  int q[N][$];
  bit pend[N], ov[N], un[N];
  int ns[N], nd[N], bz[N], stl[N], ll[N], lm[N];
  int mts;
  bit frz;
  bit ren_s;

  hls_ctrl_perf_monitor #(.N_CH(N), .DEPTH(D), .CNT_W(CW), .TS_W(TW)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish), .clear(clear),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return v >= CMAX ? CMAX : v + 1;
  endfunction

  task automatic mreset();
    for (int c = 0; c < N; c++) begin
      q[c].delete();
      pend[c] = 0; ov[c] = 0; un[c] = 0;
      ns[c] = 0; nd[c] = 0; bz[c] = 0; stl[c] = 0; ll[c] = 0; lm[c] = 0;
    end
    mts = 0;
    frz = 0;
  endtask

  function automatic int mread(input int ch, input int sel);
    if (ch >= N) return 0;
    case (sel)
      0: return ns[ch];
      1: return nd[ch];
      2: return bz[ch];
      3: return stl[ch];
      4: return ll[ch];
      5: return lm[ch];
      6: return q[ch].size() * 4 + un[ch] * 2 + ov[ch];
      default: return mts;
    endcase
  endfunction

  // One clock of the reference behaviour, using the inputs currently driven.
  task automatic mstep();
    bit was_frz = frz;
    for (int c = 0; c < N; c++) begin
      bit s, d, u, o, b;
      int lat;
      if (!was_frz) begin
        s = ap_start[c] && !pend[c];
        d = ap_done[c] && ap_continue[c];
        b = q[c].size() != 0;
        u = 0; o = 0; lat = -1;
        if (s && d && !b) lat = 0;
        else begin
          if (d) begin
            if (b) lat = (mts - q[c].pop_front()) & TMASK;
            else u = 1;
          end
          if (s) begin
            if (q[c].size() < D) q[c].push_back(mts);
            else o = 1;
          end
        end
        pend[c] = (pend[c] || ap_start[c]) && !ap_ready[c];
        if (!clear) begin
          if (s) ns[c] = sat(ns[c]);
          if (d) nd[c] = sat(nd[c]);
          if (b) bz[c] = sat(bz[c]);
          if (ap_done[c] && !ap_continue[c]) stl[c] = sat(stl[c]);
          if (lat >= 0) begin
            ll[c] = lat;
            if (lat > lm[c]) lm[c] = lat;
          end
          ov[c] |= o;
          un[c] |= u;
        end
      end
      if (clear) begin
        ns[c] = 0; nd[c] = 0; bz[c] = 0; stl[c] = 0; ll[c] = 0; lm[c] = 0; ov[c] = 0; un[c] = 0;
      end
    end
    frz = clear ? 1'b0 : (frz || finish);
    if (!was_frz) mts = (mts + 1) & TMASK;
  endtask

  task automatic go(input bit fx = 0, input int fv = 0);
    exp_t e;
    if (rd_en) begin
      e.ch = int'(rd_ch);
      e.sel = int'(rd_sel);
      e.v = fx ? fv : mread(int'(rd_ch), int'(rd_sel));
      exp_q.push_back(e);
    end
    mstep();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '1;
    finish = 0; clear = 0; rd_en = 0;
  endtask

  task automatic rd(input int ch, input int sel, input int v);
    rd_en = 1; rd_ch = 2'(ch); rd_sel = 3'(sel);
    go(1, v);
    rd_en = 0;
  endtask

  task automatic rdm(input int ch, input int sel);
    rd_en = 1; rd_ch = 2'(ch); rd_sel = 3'(sel);
    go();
    rd_en = 0;
  endtask

  task automatic wait_ts(input int t);
    while (mts != t) go();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      ren_s = rd_en && !reset;
      @(negedge clock);
      chk("rd_valid", rd_valid, ren_s);
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rd_unexpected: got rd_valid=1 expected no pending read");
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("rd ch%0d sel%0d", e.ch, e.sel), rd_data, e.v);
        end
      end
    end
  end

  initial begin
    mreset();
    #22;
    chk("reset rd_data", rd_data, 0);
    chk("reset rd_valid", rd_valid, 0);
    reset = 0;
    rdm(0, 7);
    // non-overlapped invocation on ch0
    wait_ts(10);
    ap_start = 3'b001; ap_ready = 3'b001; go(); idle();
    wait_ts(17);
    ap_done = 3'b001; go(); idle();
    rd(0, 0, 1); rd(0, 1, 1); rd(0, 2, 7); rd(0, 4, 7); rd(0, 5, 7); rd(0, 6, 0);
    rd(3, 0, 0); rd(1, 0, 0);
    // pipelined overlap on ch1
    wait_ts(5);
    repeat (3) begin
      ap_start = 3'b010; ap_ready = 3'b010; go();
    end
    idle();
    rd(1, 6, 12);
    wait_ts(20);
    ap_done = 3'b010; go(); idle();
    wait_ts(22);
    ap_done = 3'b010; go(); go(); idle();
    rd(1, 4, 16); rd(1, 5, 16); rd(1, 6, 0); rd(1, 1, 3);
    // underflow then overflow on ch2
    ap_done = 3'b100; go(); idle();
    rd(2, 6, 2); rd(2, 4, 0); rd(2, 1, 1);
    repeat (5) begin
      ap_start = 3'b100; ap_ready = 3'b100; go();
    end
    idle();
    rd(2, 6, 19); rd(2, 0, 5);
    // back-pressure on ch0
    ap_done = 3'b001; ap_continue = 3'b110;
    repeat (4) go();
    ap_continue = 3'b111; go(); idle();
    rd(0, 3, 4); rd(0, 1, 2);
    // saturation and timestamp wrap
    ap_start = 3'b010; ap_ready = 3'b010;
    repeat (300) go();
    idle();
    rd(1, 0, 255);
    wait_ts(30);
    ap_start = 3'b001; ap_ready = 3'b001; go(); idle();
    wait_ts(3);
    ap_done = 3'b001; go(); idle();
    rd(0, 4, 5); rd(0, 5, 7);
    // clear mid-flight, then finish
    wait_ts(10);
    ap_start = 3'b001; ap_ready = 3'b001; go(); idle();
    go();
    clear = 1; go(); clear = 0;
    wait_ts(15);
    ap_done = 3'b001; go(); idle();
    rd(0, 1, 1); rd(0, 4, 5); rd(0, 0, 0); rd(2, 6, 16);
    ap_start = 3'b001; ap_ready = 3'b001; finish = 1; go(); idle();
    ap_start = 3'b001; ap_done = 3'b011;
    repeat (3) go();
    idle();
    rd(0, 0, 1); rd(0, 6, 4); rd(0, 1, 1);
    rdm(0, 7); rdm(0, 7);
    clear = 1; go(); clear = 0;
    rdm(0, 7); rdm(0, 7);
    // randomized traffic with a mid-run asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        idle();
        go(); go();
        #2 reset = 1;
        #1;
        chk("async reset rd_data", rd_data, 0);
        chk("async reset rd_valid", rd_valid, 0);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 0;
        mreset();
        exp_q.delete();
      end
      ap_start = N'($urandom);
      ap_ready = N'($urandom);
      ap_done = N'($urandom & $urandom);
      ap_continue = N'($urandom | $urandom);
      finish = $urandom_range(0, 199) == 0;
      clear = $urandom_range(0, 59) == 0;
      rd_en = $urandom_range(0, 3) != 0;
      rd_ch = 2'($urandom_range(0, 3));
      rd_sel = 3'($urandom);
      go();
    end
    idle();
    go(); go();
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end
endmodule
